// File: rtl/bus_arbiter_3r_if.sv
// Bundle of requester, grant and bus-target handshake signals for bus_arbiter_3r.
// The master modport is the arbiter side; the slave modport is the requester/target side.
interface bus_arbiter_3r_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic [2:0]       req;
  logic [2:0]       lock;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       grant;
  logic [1:0]       mux_sel;
  logic [WIDTH-1:0] bus_data;
  logic             bus_valid;
  logic             bus_ready;
  logic [2:0]       done;
  logic             timeout_err;

  modport master (
    input  req, lock, data0, data1, data2, bus_ready,
    output grant, mux_sel, bus_data, bus_valid, done, timeout_err
  );

  modport slave (
    output req, lock, data0, data1, data2, bus_ready,
    input  grant, mux_sel, bus_data, bus_valid, done, timeout_err
  );

endinterface

// File: rtl/bus_arbiter_3r.sv
// Three-requester round-robin arbiter and valid/ready transfer sequencer with locked bursts.
// Optional ARB_TIMEOUT_EN: aborts a beat that waits TIMEOUT cycles for bus_ready.
module bus_arbiter_3r #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  bus_arbiter_3r_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic [WIDTH-1:0] bus_data_q, bus_data_d;
  logic             bus_valid_q, bus_valid_d;
  logic [1:0]       rr_q, rr_d;
  logic             timeout_err_q, timeout_err_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             accept;
  logic             req_g;
  logic             lock_g;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] wait_q, wait_d;
`endif

  // Modulo-3 addition of two indices in 0..2.
  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = 3'(a) + 3'(b);
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  function automatic logic [WIDTH-1:0] pick_data(input logic [1:0] idx,
                                                 input logic [WIDTH-1:0] d0,
                                                 input logic [WIDTH-1:0] d1,
                                                 input logic [WIDTH-1:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  // Winner search: scanned backwards so the first requester at or after rr_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (bus.req[add_mod3(rr_q, 2'(k))]) begin
        win_found = 1'b1;
        win_idx   = add_mod3(rr_q, 2'(k));
      end
    end
  end

  // mux_sel_q is the owner's index whenever a grant is held.
  assign accept = bus_valid_q & bus.bus_ready;
  assign req_g  = bus.req[mux_sel_q];
  assign lock_g = bus.lock[mux_sel_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 3'b000;
      mux_sel_q     <= 2'd0;
      bus_data_q    <= '0;
      bus_valid_q   <= 1'b0;
      rr_q          <= 2'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      mux_sel_q     <= mux_sel_d;
      bus_data_q    <= bus_data_d;
      bus_valid_q   <= bus_valid_d;
      rr_q          <= rr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    mux_sel_d     = mux_sel_q;
    bus_data_d    = bus_data_q;
    bus_valid_d   = bus_valid_q;
    rr_d          = rr_q;
    timeout_err_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_d        = wait_q;
`endif

    case (state_q)
      IDLE: begin
        bus_valid_d = 1'b0;
        if (win_found) begin
          grant_d     = 3'b001 << win_idx;
          mux_sel_d   = win_idx;
          bus_data_d  = pick_data(win_idx, bus.data0, bus.data1, bus.data2);
          bus_valid_d = 1'b1;
          state_d     = XFER;
`ifdef ARB_TIMEOUT_EN
          wait_d      = '0;
`endif
        end
      end

      XFER: begin
        if (accept) begin
          bus_valid_d = 1'b0;
          if (lock_g && req_g) begin
            state_d = HOLD;
          end else begin
            grant_d = 3'b000;
            rr_d    = add_mod3(mux_sel_q, 2'd1);
            state_d = IDLE;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          // The TIMEOUT-th unaccepted cycle abandons the beat without a done.
          timeout_err_d = 1'b1;
          bus_valid_d   = 1'b0;
          grant_d       = 3'b000;
          rr_d          = add_mod3(mux_sel_q, 2'd1);
          state_d       = IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
`endif
        end
      end

      HOLD: begin
        if (req_g) begin
          bus_data_d  = pick_data(mux_sel_q, bus.data0, bus.data1, bus.data2);
          bus_valid_d = 1'b1;
          state_d     = XFER;
`ifdef ARB_TIMEOUT_EN
          wait_d      = '0;
`endif
        end else begin
          grant_d = 3'b000;
          rr_d    = add_mod3(mux_sel_q, 2'd1);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.bus_data  = bus_data_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.done      = grant_q & {3{accept}};

`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // The error register only ever loads 1 with the timeout feature compiled in.
  logic unused_terr;
  assign unused_terr = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_3r.sv
// Bench for bus_arbiter_3r: directed scenarios plus random traffic, accepted beats
// scoreboarded against a transaction-level model of the arbitration rules.
module tb_bus_arbiter_3r;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_3r_if #(.WIDTH(W)) bus ();

  bus_arbiter_3r #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] word;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_bad    = 0;
  bit mon_en   = 1'b0;

  // Model: owner (-1 = none), phase 0 idle / 1 offering / 2 bubble, rotating pointer, offered word.
  int           m_owner = -1;
  int           m_phase = 0;
  int           m_rr    = 0;
  logic [W-1:0] m_word  = '0;

  logic [2:0]   s_grant, s_done;
  logic [1:0]   s_sel;
  logic [W-1:0] s_data;
  logic         s_valid, s_terr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input int i, input logic [W-1:0] d0,
                                        input logic [W-1:0] d1, input logic [W-1:0] d2);
    return (i == 0) ? d0 : (i == 1) ? d1 : d2;
  endfunction

  task automatic model_update(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                              input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic rdy);
    if (r) begin
      m_phase = 0;
      m_owner = -1;
      m_rr    = 0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_rr + k) % 3;
        if (rq[i] && m_phase == 0) begin
          m_owner = i;
          m_word  = pick(i, d0, d1, d2);
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (rdy) begin
        if (lk[m_owner] && rq[m_owner]) begin
          m_phase = 2;
        end else begin
          m_rr    = (m_owner + 1) % 3;
          m_owner = -1;
          m_phase = 0;
        end
      end
    end else begin
      if (rq[m_owner]) begin
        m_word  = pick(m_owner, d0, d1, d2);
        m_phase = 1;
      end else begin
        m_rr    = (m_owner + 1) % 3;
        m_owner = -1;
        m_phase = 0;
      end
    end
  endtask

  // One clock cycle: drive, predict accepts, snapshot outputs, advance the model.
  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input logic rdy);
    @(negedge clk);
    rst           = r;
    bus.req       = rq;
    bus.lock      = lk;
    bus.data0     = d0;
    bus.data1     = d1;
    bus.data2     = d2;
    bus.bus_ready = rdy;
    #1;
    if (!r && m_phase == 1 && rdy) exp_q.push_back(beat_t'{idx: 2'(m_owner), word: m_word});
    #1;
    s_grant = bus.grant;
    s_sel   = bus.mux_sel;
    s_data  = bus.bus_data;
    s_valid = bus.bus_valid;
    s_done  = bus.done;
    s_terr  = bus.timeout_err;
    @(posedge clk);
    model_update(r, rq, lk, d0, d1, d2, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 3'b000, 3'b000, '0, '0, '0, 1'b0);
  endtask

  // Monitor: per-cycle grant/valid against the model, accepted beats against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : 32'(3'b001 << m_owner));
        check("bus_valid", 32'(bus.bus_valid), 32'(m_phase == 1));
        if (m_owner >= 0) check("mux_sel", 32'(bus.mux_sel), 32'(m_owner));
        if (bus.done != 3'b000) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("done", 32'(bus.done), 32'(3'b001 << b.idx));
            check("beat_data", 32'(bus.bus_data), 32'(b.word));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0] t2_grant [8];

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.lock      = '0;
    bus.data0     = '0;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.bus_ready = 1'b0;
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // Single grant to requester 1
    step(1'b0, 3'b010, 3'b000, '0, 16'hBEEF, '0, 1'b1);
    check("rst_grant", 32'(s_grant), 32'd0);
    check("rst_mux_sel", 32'(s_sel), 32'd0);
    check("rst_bus_data", 32'(s_data), 32'd0);
    check("rst_bus_valid", 32'(s_valid), 32'd0);
    check("rst_timeout_err", 32'(s_terr), 32'd0);
    step(1'b0, 3'b000, 3'b000, '0, 16'hBEEF, '0, 1'b1);
    check("t1_grant", 32'(s_grant), 32'h2);
    check("t1_mux_sel", 32'(s_sel), 32'd1);
    check("t1_bus_data", 32'(s_data), 32'hBEEF);
    check("t1_valid", 32'(s_valid), 32'd1);
    check("t1_done", 32'(s_done), 32'h2);
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b1);
    check("t1_idle_grant", 32'(s_grant), 32'd0);
    check("t1_idle_valid", 32'(s_valid), 32'd0);
    check("t1_idle_sel_hold", 32'(s_sel), 32'd1);

    // All three requesting: rotation 0,1,2,0 with an idle cycle between grants
    do_reset();
    t2_grant = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b111, 3'b000, W'($urandom), W'($urandom), W'($urandom), 1'b1);
      check("t2_grant", 32'(s_grant), 32'(t2_grant[i]));
    end
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b1);

    // Locked 3-beat burst from requester 0 while requester 2 waits
    do_reset();
    step(1'b0, 3'b101, 3'b001, 16'd1, '0, 16'h2222, 1'b1);
    step(1'b0, 3'b101, 3'b001, 16'd1, '0, 16'h2222, 1'b1);
    check("t3_b1_data", 32'(s_data), 32'd1);
    check("t3_b1_done", 32'(s_done), 32'h1);
    step(1'b0, 3'b101, 3'b001, 16'd2, '0, 16'h2222, 1'b1);
    check("t3_hold_valid", 32'(s_valid), 32'd0);
    check("t3_hold_grant", 32'(s_grant), 32'h1);
    step(1'b0, 3'b101, 3'b001, 16'd2, '0, 16'h2222, 1'b1);
    check("t3_b2_data", 32'(s_data), 32'd2);
    step(1'b0, 3'b101, 3'b001, 16'd3, '0, 16'h2222, 1'b1);
    check("t3_hold2_valid", 32'(s_valid), 32'd0);
    step(1'b0, 3'b101, 3'b000, 16'd3, '0, 16'h2222, 1'b1);
    check("t3_b3_data", 32'(s_data), 32'd3);
    check("t3_b3_grant", 32'(s_grant), 32'h1);
    step(1'b0, 3'b101, 3'b000, 16'd4, '0, 16'h2222, 1'b0);
    check("t3_gap_grant", 32'(s_grant), 32'd0);
    step(1'b0, 3'b101, 3'b000, 16'd4, '0, 16'h2222, 1'b1);
    check("t3_next_grant", 32'(s_grant), 32'h4);
    check("t3_next_data", 32'(s_data), 32'h2222);
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b0);

    // Requester 2 stalled by bus_ready for five cycles
    do_reset();
    step(1'b0, 3'b100, 3'b000, '0, '0, 16'h1234, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 3'b100, 3'b000, W'($urandom), W'($urandom), W'($urandom), (k == 6));
      check("t4_sel", 32'(s_sel), 32'd2);
      check("t4_data", 32'(s_data), 32'h1234);
      check("t4_done", 32'(s_done), (k == 6) ? 32'h4 : 32'h0);
    end
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b0);
    check("t4_idle_grant", 32'(s_grant), 32'd0);

    // Reset mid-transfer restarts the round-robin pointer at 0
    do_reset();
    step(1'b0, 3'b001, 3'b000, 16'h0A0A, '0, '0, 1'b1);
    step(1'b0, 3'b011, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b1);
    step(1'b0, 3'b011, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b0);
    step(1'b0, 3'b011, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b0);
    check("t5_pre_grant", 32'(s_grant), 32'h2);
    step(1'b1, 3'b011, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b0);
    step(1'b0, 3'b011, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b0);
    check("t5_rst_grant", 32'(s_grant), 32'd0);
    check("t5_rst_valid", 32'(s_valid), 32'd0);
    check("t5_rst_data", 32'(s_data), 32'd0);
    step(1'b0, 3'b000, 3'b000, 16'h0A0A, 16'h0B0B, '0, 1'b1);
    check("t5_regrant", 32'(s_grant), 32'h1);
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b0);

`ifndef ARB_TIMEOUT_EN
    // Without the timeout feature an unanswered beat is offered indefinitely
    do_reset();
    step(1'b0, 3'b001, 3'b000, 16'h5A5A, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 3'b001, 3'b000, 16'h5A5A, '0, '0, 1'b0);
      check("t6_terr", 32'(s_terr), 32'd0);
    end
    check("t6_valid", 32'(s_valid), 32'd1);
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b1);
    step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      step(1'b0, 3'($urandom), 3'($urandom), W'($urandom), W'($urandom), W'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    for (int n = 0; n < 6; n++) step(1'b0, 3'b000, 3'b000, '0, '0, '0, 1'b1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_3r.md
Name: bus_arbiter_3r

Overview:
- Round-robin arbiter and transfer sequencer for one shared 16-bit bus fed by three requesters.
- Picks one requester and drives the 3-input select code (0/1/2) to the bus-side mux.
- Registers the chosen 16-bit word and runs a valid/ready handshake with the bus target.
- Supports locked multi-beat bursts. Sits between the register-file/ALU/memory write-back sources and the shared result bus.

Parameters:
- WIDTH, 16, data width of each requester word and of bus_data.
- TIMEOUT, 15, max cycles bus_valid may wait for bus_ready; used only with ARB_TIMEOUT_EN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  3  request per requester; bit i = requester i.
- lock  input  3  requester i wants to keep its grant for another beat after the current one.
- data0  input  WIDTH  requester 0 word; valid while req[0]=1.
- data1  input  WIDTH  requester 1 word; valid while req[1]=1.
- data2  input  WIDTH  requester 2 word; valid while req[2]=1.
- grant  output  3  one-hot registered grant; 0 when idle.
- mux_sel  output  2  select code 0/1/2 of the granted requester; never 3.
- bus_data  output  WIDTH  registered word being offered.
- bus_valid  output  1  bus_data is offered to the target.
- bus_ready  input  1  target accepts when bus_valid=1 and bus_ready=1.
- done  output  3  combinational: done[i] = grant[i] & bus_valid & bus_ready.
- timeout_err  output  1  one-cycle pulse on an aborted transfer (ARB_TIMEOUT_EN only; else tied 0).

Behaviour:
- Reset values: grant=0, mux_sel=0, bus_data=0, bus_valid=0, timeout_err=0, FSM=IDLE, rr_ptr=0. Reset overrides everything, including mid-transfer; nothing is completed or reported.
- rr_ptr (0..2) marks the highest-priority requester. Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- IDLE:
  - If req is nonzero, on the clock edge: grant=onehot(winner), mux_sel=winner, bus_data=data[winner], bus_valid=1, go to XFER.
  - Latency is 1 cycle from req high to bus_valid high.
  - If req=0, stay in IDLE; outputs hold except bus_valid=0.
- XFER:
  - bus_valid=1. bus_data, grant and mux_sel are held stable until accept.
  - Accept = bus_valid & bus_ready. done[g] is high in the accept cycle.
  - On accept with lock[g]=1 and req[g]=1: go to HOLD. The requester updates its data at the same edge.
  - On accept otherwise: grant=0, bus_valid=0, rr_ptr=(g+1) mod 3, go to IDLE.
  - If req[g] drops before accept, it is ignored; the beat completes anyway.
- HOLD (one bubble cycle):
  - bus_valid=0, grant held.
  - At the end of HOLD: bus_data=data[g], bus_valid=1, go to XFER.
  - If req[g]=0 at the end of HOLD: grant=0, rr_ptr=(g+1) mod 3, go to IDLE.
  - Locked throughput is 1 beat per 2 cycles. Other requesters are starved for the whole lock by design.
- Simultaneous events:
  - A new req arriving in the accept cycle is evaluated in the following IDLE cycle. Minimum gap between two different grants is 1 idle cycle.
  - Inputs req=3'b111 with rr_ptr=0 grant order 0,1,2,0...
- mux_sel always equals the index of the set grant bit, or holds its last value while idle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A 4-bit+ wait counter clears on entry to XFER and increments each XFER cycle without accept.
  - When it reaches TIMEOUT: timeout_err=1 for one cycle, bus_valid=0, grant=0, rr_ptr=(g+1) mod 3, go to IDLE.
  - done is not asserted for the aborted beat.
- When undefined: no counter, timeout_err constant 0, XFER waits indefinitely.

Test Plan:
- Reset, then req=3'b010, data1=16'hBEEF, bus_ready=1 -> next cycle grant=3'b010, mux_sel=1, bus_data=16'hBEEF, bus_valid=1, done=3'b010; then IDLE with grant=0.
- req=3'b111 held, bus_ready=1 -> grants cycle 001,010,100,001 with one idle cycle between each; mux_sel 0,1,2,0.
- req[0]=1, lock[0]=1 for 3 beats, data0=1,2,3 updated on done, req[2]=1 throughout -> bus_data 1,2,3 on consecutive XFER cycles separated by HOLD bubbles; requester 2 granted only after lock drops.
- Grant requester 2, bus_ready=0 for 5 cycles then 1 -> bus_data/mux_sel=2 stable all 6 cycles; done[2] only in the 6th.
- Assert reset during XFER -> next cycle all outputs 0, FSM IDLE; pending req is re-arbitrated from rr_ptr=0.
- With ARB_TIMEOUT_EN, TIMEOUT=15, bus_ready=0 -> timeout_err pulses on the 15th XFER cycle, grant=0 next, no done. Without the macro -> bus_valid stays 1 indefinitely.
